// File: rtl/div_ctrl_pkg.sv
// Shared constants for the iterative divider: FSM state encodings and iteration count.
package div_ctrl_pkg;

  typedef logic [1:0] div_state_t;

  localparam div_state_t ST_IDLE    = 2'd0;
  localparam div_state_t ST_DIVZERO = 2'd1;
  localparam div_state_t ST_ON      = 2'd2;
  localparam div_state_t ST_END     = 2'd3;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the
// partial remainder and appends the resulting quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_qbit;

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted
  // value and the top bit of the difference is a clean borrow flag.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_dsr};
  assign w_qbit  = ~w_diff[WIDTH];

  assign o_rem = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_qbit};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU unit: 32-step restoring divider with sign fixup,
// divide-by-zero shortcut, pipeline stall request and annul support.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic             stallreq,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_dvd_raw;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_accept;
  logic             w_last_step;

  // Magnitudes are taken only for DIV; 0x80000000 wraps to itself, which the
  // unsigned datapath handles correctly.
  assign w_dvd_neg = op_signed & dividend[WIDTH-1];
  assign w_dsr_neg = op_signed & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? ({WIDTH{1'b0}} - dividend) : dividend;
  assign w_dsr_mag = w_dsr_neg ? ({WIDTH{1'b0}} - divisor)  : divisor;

  assign w_accept    = (r_state == ST_IDLE) & start & ~annul;
  assign w_last_step = (r_state == ST_ON) & (r_cnt == CNT_LAST);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dsr (r_dsr),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  assign w_quo_fix = r_q_neg ? ({WIDTH{1'b0}} - w_step_quo) : w_step_quo;
  assign w_rem_fix = r_r_neg ? ({WIDTH{1'b0}} - w_step_rem) : w_step_rem;

  // NOTE: default assignment first so every path drives w_state_nxt and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (annul) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) w_state_nxt = (divisor == '0) ? ST_DIVZERO : ST_ON;
        end
        ST_ON:      if (r_cnt == CNT_LAST) w_state_nxt = ST_END;
        ST_DIVZERO: w_state_nxt = ST_END;
        ST_END:     w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: all state, including datapath and result registers, is cleared by the
  // asynchronous reset; non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dsr       <= '0;
      r_dvd_raw   <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (annul || r_state != ST_ON || r_cnt == CNT_LAST) r_cnt <= '0;
      else                                                r_cnt <= r_cnt + CNT_W'(1);

      if (w_accept) begin
        r_rem     <= '0;
        r_quo     <= w_dvd_mag;
        r_dsr     <= w_dsr_mag;
        r_dvd_raw <= dividend;
        r_q_neg   <= w_dvd_neg ^ w_dsr_neg;
        r_r_neg   <= w_dvd_neg;
      end else if (r_state == ST_ON && !annul) begin
        r_rem <= w_step_rem;
        r_quo <= w_step_quo;
      end

      // Results load on the edge into END so they are stable during the strobe
      // and then hold until the next completed operation.
      if (!annul) begin
        if (w_last_step) begin
          r_quotient  <= w_quo_fix;
          r_remainder <= w_rem_fix;
        end else if (r_state == ST_DIVZERO) begin
          r_quotient  <= '1;
          r_remainder <= r_dvd_raw;
        end
      end
    end
  end

  assign stallreq = ((start & (r_state != ST_END) & ~annul) |
                     (r_state == ST_ON) | (r_state == ST_DIVZERO)) & ~annul;
  assign result_valid = (r_state == ST_END) & ~annul;
  assign quotient     = r_quotient;
  assign remainder    = r_remainder;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed corner cases plus randomized DIV/DIVU
// traffic checked against an arithmetic reference model.
module tb_div_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         op_signed;
  logic         annul;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         stallreq;
  logic         result_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  div_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op_signed    (op_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .annul        (annul),
    .stallreq     (stallreq),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           t0;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   n_results = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; signed uses 64-bit truncating arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   m;
    longint sa, sb, lq, lr;
    m.t0  = 0;
    m.lat = 0;
    if (b == '0) begin
      m.q = '1;
      m.r = a;
    end else if (s) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lq  = sa / sb;
      lr  = sa % sb;
      m.q = lq[W-1:0];
      m.r = lr[W-1:0];
    end else begin
      m.q = a / b;
      m.r = a % b;
    end
    return m;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && result_valid === 1'b1) begin
      n_results++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  // Called just after a rising edge: that cycle is cycle 0 of the operation.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
    exp_t e;
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    op_signed = s;
    if (push) begin
      e     = model(a, b, s);
      e.t0  = cyc;
      e.lat = (b == '0) ? 2 : 33;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bit busy_ok = 1'b1;
    bit done    = 1'b0;
    issue(a, b, s, 1'b1);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        done = 1'b1;
        check("stall_in_end", 32'(stallreq), 32'd0);
      end else begin
        if (stallreq !== 1'b1) busy_ok = 1'b0;
        if (i > 0) begin
          dividend  = $urandom;
          divisor   = $urandom;
          op_signed = 1'($urandom_range(0, 1));
        end
      end
    end
    check("stall_busy", 32'(busy_ok), 32'd1);
    check("completed", 32'(done), 32'd1);
    if (!done) exp_q.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int gap;
    rst       = 1'b0;
    start     = 1'b0;
    op_signed = 1'b0;
    annul     = 1'b0;
    dividend  = '0;
    divisor   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stallreq", 32'(stallreq), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    do_div(32'd100, 32'd7, 1'b0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    do_div(32'd5, 32'd0, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // Annul in cycle 10 of a divide.
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (10) tick();
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("annul_stall", 32'(stallreq), 32'd0);
    check("annul_valid", 32'(result_valid), 32'd0);
    tick();
    annul = 1'b0;
    base  = n_results;
    @(negedge clk);
    check("stall_after_annul", 32'(stallreq), 32'd0);
    repeat (40) @(negedge clk);
    check("no_valid_after_annul", 32'(n_results), 32'(base));
    tick();
    do_div(32'd9, 32'd3, 1'b0);

    // Asynchronous reset in cycle 20 of a divide.
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (20) tick();
    #2;
    rst   = 1'b0;
    start = 1'b0;
    #1;
    check("midrst_stallreq", 32'(stallreq), 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    repeat (2) tick();
    rst  = 1'b1;
    base = n_results;
    repeat (40) @(negedge clk);
    check("no_valid_after_rst", 32'(n_results), 32'(base));
    check("quotient_held_zero", quotient, 32'd0);
    tick();

    // Random traffic; gap 0 keeps start high straight out of END.
    for (int k = 0; k < 40; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      do_div(pick(), pick(), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is required to be supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  EX requests a divide; held high until result_valid is seen.
REQ-005 SHALL have port op_signed  input  1  1=DIV (signed), 0=DIVU; sampled with start in IDLE.
REQ-006 SHALL have port dividend  input  WIDTH  numerator; sampled with start in IDLE.
REQ-007 SHALL have port divisor  input  WIDTH  denominator; sampled with start in IDLE.
REQ-008 SHALL have port annul  input  1  pipeline flush; aborts any operation in progress.
REQ-009 SHALL have port stallreq  output  1  stall request to the stall controller while a divide is pending.
REQ-010 SHALL have port result_valid  output  1  one-cycle strobe; quotient and remainder are valid.
REQ-011 SHALL have port quotient  output  WIDTH  LO write data.
REQ-012 SHALL have port remainder  output  WIDTH  HI write data.

Function
REQ-013 SHALL implement the FSM states IDLE, DIVZERO, ON and END.
REQ-014 IDLE: start=1 & annul=0 & divisor!=0 SHALL go to ON; with divisor==0 it SHALL go to DIVZERO; otherwise it SHALL stay in IDLE.
REQ-015 On leaving IDLE, SHALL latch |dividend| and |divisor|, where the magnitude is taken only if op_signed, plus the quotient sign (sign XOR) and the remainder sign (dividend sign).
REQ-016 ON: SHALL perform one restoring shift-subtract step per cycle; a 6-bit counter counts 0..31; at count 31 it SHALL go to END.
REQ-017 DIVZERO: SHALL go to END after 1 cycle with quotient=all-ones and remainder=dividend (unsigned raw value).
REQ-018 END: result_valid=1 for exactly that cycle, then SHALL return to IDLE unconditionally.
REQ-019 Latency SHALL be: start sampled in cycle 0, ON in cycles 1..32, END (result_valid) in cycle 33; divide-by-zero SHALL reach END in cycle 2.
REQ-020 Signed fixup SHALL apply at END: the quotient is negated if the quotient sign is set; the remainder is negated if the remainder sign is set; arithmetic is mod 2^WIDTH.
REQ-021 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-022 stallreq SHALL be combinational: (start & state!=END & ~annul) | (state==ON) | (state==DIVZERO), then masked by annul.
REQ-023 annul=1 in any state SHALL force IDLE on the next edge, suppress result_valid that cycle, and leave the counter cleared.
REQ-024 If start is still high in the cycle after END, a new divide SHALL begin; EX is responsible for dropping start.
REQ-025 Operand changes while not in IDLE SHALL be ignored.
REQ-026 quotient and remainder SHALL hold their last END value until the next END.

Reset
REQ-027 rst=0 SHALL asynchronously set state=IDLE and counter=0, and clear all datapath registers.
REQ-028 After reset, stallreq, result_valid, quotient and remainder SHALL all be 0.
REQ-029 Reset mid-operation SHALL discard the operation; no result_valid SHALL follow.

Structure
REQ-030 FSM state encodings and the iteration count (32) SHALL live in the shared defines header.
REQ-031 One combinational sub-module, div_step, SHALL compute a single shift-subtract iteration (partial remainder and quotient bit).
REQ-032 FSM, counter, sign latches and fixup SHALL reside in div_ctrl.

Verification
REQ-033 DIVU: 100/7 -> result_valid in cycle 33, quotient=14, remainder=2; stallreq high in cycles 0..32.
REQ-034 DIV: -7/2 (0xFFFFFFF9/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-035 Divide by zero: 5/0 -> result_valid in cycle 2, quotient=0xFFFFFFFF, remainder=5.
REQ-036 Overflow: DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-037 annul in cycle 10 of a divide -> IDLE next cycle, stallreq low, no result_valid; a following 9/3 -> quotient=3, remainder=0.
REQ-038 rst low in cycle 20 -> all outputs 0 immediately (asynchronously); no later result_valid.
